mac_seq: RTL and testbench

Operand sequencer driving the control side of the 8-bit `MAC` accumulator (`En`/`Clr`/`Ain`/`Bin` in, `Cout` out).
- Accepts a dot-product command of length N.
- Clears the MAC, then streams N operand pairs from two valid/ready input streams into it.
- Captures the final `Cout` and presents it on a valid/ready result port.
- Sits between the operand FIFOs and one MAC instance, one sequencer per MAC.

---
 rtl/mac_seq.sv | 131 +++++++++++++
 tb/tb_mac_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: operand sequencer for one 8-bit MAC accumulator.
// Takes a dot-product command of length N. It clears the MAC, streams N
// operand pairs into it from the A and B streams, then presents the final
// accumulator value on the result port.
// Optional feature macro: MAC_SEQ_STALL_CNT_EN adds a 16-bit stall counter
// output. The counter clears in CLEAR and counts RUN cycles in which no pair
// was consumed.
//
// Handshake rule, used on every valid/ready pair in this block: a transfer
// happens on a rising edge where both valid and ready are high. A producer
// holds valid and data stable until that edge. Here ready never depends on a
// lone valid: A and B are accepted together or not at all.
module mac_seq #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_data,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
`ifdef MAC_SEQ_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [LEN_W-1:0] remaining;
    logic [ACC_W-1:0] res_q;
    logic             fire;

    // A pair is consumed only in RUN, and only when both operands are present.
    assign fire = (state == S_RUN) && a_valid && b_valid;

    // Control outputs decoded straight from the state and the joined handshake.
    always_comb begin
        busy      = (state != S_IDLE);
        mac_clr   = (state == S_CLEAR);
        mac_en    = fire;
        a_ready   = fire;
        b_ready   = fire;
        mac_a     = fire ? a_data : '0;
        mac_b     = fire ? b_data : '0;
        res_valid = (state == S_DONE);
        res_data  = res_q;
        state_dbg = state;
    end

    // Sequencing FSM, remaining-pair down-counter and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            res_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= len;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state <= (remaining == '0) ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    if (fire) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The MAC registered the last product on the previous edge.
                    res_q <= mac_cout;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count RUN cycles without a transfer. The count saturates and is held
    // outside CLEAR/RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state == S_CLEAR) begin
            stall_q <= '0;
        end else if ((state == S_RUN) && !fire && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: randomized bench for mac_seq with a behavioural MAC beside it.
// The expected result of each command is the plain sum of the products of
// its operand pairs. It is pushed onto exp_q before the command runs.
// Build with MAC_SEQ_STALL_CNT_EN defined to also check stall_cnt.
module tb_mac_seq;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              a_valid, a_ready, b_valid, b_ready;
    logic [DATA_W-1:0] a_data, b_data;
    logic              mac_en, mac_clr;
    logic [DATA_W-1:0] mac_a, mac_b;
    logic [ACC_W-1:0]  mac_cout;
    logic              res_valid, res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [2:0]        state_dbg;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    mac_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_cout  (mac_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
`ifdef MAC_SEQ_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .state_dbg (state_dbg)
    );

    // The MAC the sequencer drives. It shares rst_n with the sequencer.
    logic [ACC_W-1:0] acc;
    always_ff @(posedge clk) begin
        if (!rst_n)       acc <= '0;
        else if (mac_clr) acc <= '0;
        else if (mac_en)  acc <= acc + ACC_W'(mac_a) * ACC_W'(mac_b);
    end
    assign mac_cout = acc;

    // ---------------- scoreboard ----------------
    logic [ACC_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus state ----------------
    int a_vals[256];
    int b_vals[256];
    int offer;      // number of pairs the streams present (may exceed N)
    int a_drop;     // percent chance A is withheld in a cycle
    int b_drop;
    int gap_idx;    // hold A low for gap_len cycles before pair gap_idx
    int gap_len;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_en"},    mac_en, 0);
        check_eq({tag, "_clr"},   mac_clr, 0);
        check_eq({tag, "_ar"},    a_ready, 0);
        check_eq({tag, "_br"},    b_ready, 0);
        check_eq({tag, "_rv"},    res_valid, 0);
        check_eq({tag, "_ma"},    mac_a, 0);
        check_eq({tag, "_mb"},    mac_b, 0);
        check_eq({tag, "_rd"},    res_data, 0);
    endtask

    // Driver: issue one command of length n and drive the operand streams.
    // Check handshakes every cycle and the result against the scoreboard.
    // bp = number of res_valid cycles with res_ready held low.
    // exp_lat >= 0 adds an explicit latency check.
    task automatic run_cmd(input int n, input int bp, input int exp_lat, input string tag);
        longint sum;
        int c, ai, fires, stalls, rv_cnt, lat, first_en, en_cnt, clr_cnt;
        logic gate_a, gate_b, acc_hs, done_flag;
        logic [ACC_W-1:0] held;
        int gap_left;

        sum = 0;
        for (int i = 0; i < n; i++) sum += longint'(a_vals[i]) * longint'(b_vals[i]);
        exp_q.push_back(ACC_W'(sum));

        // cycle 0: start is sampled at edge T0
        start = 1'b1;
        len = LEN_W'(n);
        a_valid = 1'b0;
        b_valid = 1'b0;
        res_ready = 1'b0;
        step();
        start = 1'b0;
        c = 1; ai = 0; fires = 0; stalls = 0; rv_cnt = 0; lat = -1;
        first_en = -1; en_cnt = 0; clr_cnt = 0; done_flag = 1'b0;
        held = '0; gap_left = gap_len;

        while (!done_flag && c < 3000) begin
            // drive inputs for cycle c
            gate_a = ($urandom_range(99) >= a_drop);
            gate_b = ($urandom_range(99) >= b_drop);
            if (c >= 2 && ai == gap_idx && gap_left > 0) begin
                gate_a = 1'b0;
                gap_left--;
            end
            a_valid = (ai < offer) && gate_a;
            b_valid = (ai < offer) && gate_b;
            a_data  = a_valid ? DATA_W'(a_vals[ai]) : DATA_W'($urandom);
            b_data  = b_valid ? DATA_W'(b_vals[ai]) : DATA_W'($urandom);
            res_ready = (rv_cnt >= bp);
            start = (rv_cnt > 0 && !res_ready) ? 1'($urandom_range(1)) : 1'b0;
            #1;
            // sample
            check_eq({tag, "_busy"}, busy, 1);
            check_eq({tag, "_join"}, a_ready, b_ready);
            if (a_ready) check_eq({tag, "_rdy_needs_both"}, a_valid && b_valid, 1);
            check_eq({tag, "_en_eq_rdy"}, mac_en, a_ready);
            check_eq({tag, "_mac_a"}, mac_a, a_ready ? a_data : '0);
            check_eq({tag, "_mac_b"}, mac_b, b_ready ? b_data : '0);
            check_eq({tag, "_clr_c1"}, mac_clr, c == 1);
            if (mac_clr) clr_cnt++;
            if (mac_en) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
            end
            if (c >= 2 && fires < n && !(a_valid && b_valid)) stalls++;
            if (res_valid) begin
                if (rv_cnt == 0) begin
                    lat = c;
                    held = res_data;
                    check_eq({tag, "_res"}, res_data, exp_q.pop_front());
`ifdef MAC_SEQ_STALL_CNT_EN
                    check_eq({tag, "_stall_cnt"}, stall_cnt, stalls);
`endif
                end else begin
                    check_eq({tag, "_res_stable"}, res_data, held);
                end
                rv_cnt++;
            end
            acc_hs = res_valid && res_ready;
            if (a_ready && b_ready) begin
                ai++;
                fires++;
            end
            step();
            c++;
            if (acc_hs) done_flag = 1'b1;
        end

        if (!done_flag) check_eq({tag, "_timeout"}, 0, 1);
        // cycle Tk+1 after the accepting edge, then one more idle cycle
        start = 1'b0;
        res_ready = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_rv"}, res_valid, 0);
        step();
        check_eq({tag, "_idle_busy2"}, busy, 0);
        check_eq({tag, "_fires"}, fires, n);
        check_eq({tag, "_en_cnt"}, en_cnt, n);
        check_eq({tag, "_clr_cnt"}, clr_cnt, 1);
        check_eq({tag, "_lat_rule"}, lat, n + 3 + stalls);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
        if (n > 0 && a_drop == 0 && b_drop == 0 && gap_len == 0)
            check_eq({tag, "_first_en"}, first_en, 2);
    endtask

    task automatic clean_streams();
        offer = 0; a_drop = 0; b_drop = 0; gap_idx = -1; gap_len = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int fires;
        rst_n = 1'b0; start = 1'b0; len = '0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h12; b_data = 8'h34;
        res_ready = 1'b0;
        clean_streams();
        repeat (3) step();
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        // ordinary command
        clean_streams();
        a_vals[0] = 3;  b_vals[0] = 7;
        a_vals[1] = 10; b_vals[1] = 5;
        offer = 2;
        run_cmd(2, 0, 5, "ord");

        // zero length with streams valid that must not be consumed
        clean_streams();
        a_vals[0] = 8'hAA; b_vals[0] = 8'h55;
        offer = 1;
        run_cmd(0, 0, 3, "zero");

        // operand stall: A withheld 2 cycles before the second pair
        clean_streams();
        a_vals[0] = 2; b_vals[0] = 4;
        a_vals[1] = 7; b_vals[1] = 6;
        a_vals[2] = 1; b_vals[2] = 1;
        offer = 3; gap_idx = 1; gap_len = 2;
        run_cmd(3, 0, 8, "stall");

        // maximum length, all 255, back-pressure of 10 cycles with start pulses
        clean_streams();
        for (int i = 0; i < 255; i++) begin
            a_vals[i] = 255; b_vals[i] = 255;
        end
        offer = 255;
        run_cmd(255, 10, 258, "max");
        check_eq("max_sum_const", exp_q.size(), 0);

        // reset mid-run after 2 fires
        clean_streams();
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        fires = 0;
        for (int k = 0; k < 20 && fires < 2; k++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = DATA_W'($urandom_range(1, 255));
            b_data = DATA_W'($urandom_range(1, 255));
            #1;
            if (a_ready && b_ready) fires++;
            step();
        end
        check_eq("rst_mid_fires", fires, 2);
        rst_n = 1'b0;
        step();
        #1;
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        a_vals[0] = 3; b_vals[0] = 7;
        offer = 1;
        run_cmd(1, 0, 4, "after_rst");

        // randomized commands
        for (int t = 0; t < 8; t++) begin
            clean_streams();
            n = $urandom_range(0, 24);
            for (int i = 0; i <= n; i++) begin
                a_vals[i] = $urandom_range(0, 255);
                b_vals[i] = $urandom_range(0, 255);
            end
            offer = n + $urandom_range(0, 1);
            a_drop = $urandom_range(0, 40);
            b_drop = $urandom_range(0, 40);
            run_cmd(n, $urandom_range(0, 4), -1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
